// File: rtl/core_pkg.sv
// Shared RV32I core definitions: data width, instruction field positions
// and the fetch-stage state encoding.
package core_pkg;

    localparam int XLEN = 32;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_MSB = 31;

    typedef enum logic [1:0] {
        FS_RESET = 2'd0,
        FS_RUN   = 2'd1,
        FS_FAULT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; push and pop in one cycle are both
// honoured, including push while full when a pop frees the slot.
module fetch_fifo #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop    = pop && (count != '0);
    assign do_push   = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head_data = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: PC, request issue, in-order instruction buffer and
// redirect squash. FETCH_MISALIGN_TRAP_EN adds the misaligned-redirect FAULT state.
//
// state    | meaning
// FS_RESET | held in reset; no requests, decode idle
// FS_RUN   | normal sequential fetch
// FS_FAULT | misaligned redirect seen; fetch halted until an aligned redirect
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [XLEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic [6:0]      dec_opcode,
    output logic [2:0]      dec_funct3,
    output logic [6:0]      dec_funct7
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            misalign_fault
`endif
);

    localparam int             CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(FIFO_DEPTH);

    fetch_state_e      state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W-1:0]  discard_q, discard_d;
    logic [CNT_W-1:0]  ifq_count, pcq_count;
    logic [2*XLEN-1:0] ifq_head;
    logic [XLEN-1:0]   pcq_head;
    logic [XLEN-1:0]   redirect_target;
    logic [CNT_W:0]    occupancy;
    logic              misaligned;
    logic              dec_pop;
    logic              req_fire;
    logic              rsp_seen;
    logic              rsp_keep;
    logic              pcq_push;

    always_comb begin
`ifdef FETCH_MISALIGN_TRAP_EN
        misaligned      = (redirect_pc[1:0] != 2'b00);
        redirect_target = redirect_pc;
`else
        misaligned      = 1'b0;
        redirect_target = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
`endif
        dec_valid = (state_q == FS_RUN) && (ifq_count != '0) && !redirect_valid;
        dec_pop   = dec_valid && dec_ready;

        // A slot freed by this cycle's pop is reusable at once, so a depth-2
        // buffer sustains one instruction per cycle with 1-cycle memory.
        occupancy      = {1'b0, ifq_count} + {1'b0, inflight_q} - {{CNT_W{1'b0}}, dec_pop};
        imem_req_valid = (state_q == FS_RUN) && (occupancy < DEPTH_W);
        req_fire       = imem_req_valid && imem_req_ready;

        rsp_seen = imem_rsp_valid && (inflight_q != '0);
        rsp_keep = rsp_seen && (discard_q == '0) && (pcq_count != '0)
                   && (state_q == FS_RUN) && !redirect_valid;
        pcq_push = req_fire && !redirect_valid;

        inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(rsp_seen);

        discard_d = discard_q;
        if (redirect_valid) begin
            discard_d = inflight_d;
        end else if (rsp_seen && (discard_q != '0)) begin
            discard_d = discard_q - 1'b1;
        end

        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_target;
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end

        state_d = state_q;
        case (state_q)
            FS_RESET: state_d = (redirect_valid && misaligned) ? FS_FAULT : FS_RUN;
            FS_RUN:   if (redirect_valid && misaligned)  state_d = FS_FAULT;
            FS_FAULT: if (redirect_valid && !misaligned) state_d = FS_RUN;
            default:  state_d = FS_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= FS_RESET;
            fetch_pc_q <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    fetch_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_instr_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_data ({imem_rsp_data, pcq_head}),
        .pop       (dec_pop),
        .head_data (ifq_head),
        .count     (ifq_count)
    );

    // Address of each live request, consumed as its response is buffered.
    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_pc_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (pcq_push),
        .push_data (fetch_pc_q),
        .pop       (rsp_keep),
        .head_data (pcq_head),
        .count     (pcq_count)
    );

    assign imem_req_addr = fetch_pc_q;
    assign dec_instr     = ifq_head[2*XLEN-1:XLEN];
    assign dec_pc        = ifq_head[XLEN-1:0];
    assign dec_opcode    = dec_instr[OPCODE_MSB:OPCODE_LSB];
    assign dec_funct3    = dec_instr[FUNCT3_MSB:FUNCT3_LSB];
    assign dec_funct7    = dec_instr[FUNCT7_MSB:FUNCT7_LSB];
`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_fault = (state_q == FS_FAULT);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with RESET_PC=0x100 and a queue-based
// instruction memory whose response latency can be stretched.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [6:0]  dec_opcode;
    logic [2:0]  dec_funct3;
    logic [6:0]  dec_funct7;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_fault;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_pc;
    logic        rsp_en;
    logic [31:0] pend[$];

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC   (32'h0000_0100),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_opcode     (dec_opcode),
        .dec_funct3     (dec_funct3),
        .dec_funct7     (dec_funct7)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_fault (misalign_fault)
`endif
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a << 7) ^ 32'hFE01_2A93;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // One clock: memory accepts the pending request, then answers in order
    // from the next cycle onward while rsp_en is set.
    task automatic cyc();
        logic        f;
        logic [31:0] a;
        #1;
        f = (imem_req_valid === 1'b1) && imem_req_ready;
        a = imem_req_addr;
        @(posedge clk);
        @(negedge clk);
        redirect_valid = 1'b0;
        if (!rst_n) begin
            pend.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end else begin
            if (f) pend.push_back(a);
            if (rsp_en && pend.size() > 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = instr_of(pend.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
        end
        #1;
    endtask

    // Any instruction consumed this cycle must be the next in program order.
    task automatic cyc_chk();
        logic [31:0] e;
        if (dec_valid === 1'b1 && dec_ready) begin
            e = instr_of(exp_pc);
            chk("dec_pc", dec_pc, exp_pc);
            chk("dec_instr", dec_instr, e);
            chk("dec_opcode", {25'b0, dec_opcode}, {25'b0, e[6:0]});
            chk("dec_funct3", {29'b0, dec_funct3}, {29'b0, e[14:12]});
            chk("dec_funct7", {25'b0, dec_funct7}, {25'b0, e[31:25]});
            exp_pc = exp_pc + 32'd4;
        end
        cyc();
    endtask

    task automatic pop_n(input int n);
        int w;
        for (int k = 0; k < n; k++) begin
            w = 0;
            while (!(dec_valid === 1'b1 && dec_ready) && w < 10) begin
                cyc();
                w++;
            end
            chk("dec_wait", {31'b0, w < 10}, 32'd1);
            cyc_chk();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        rsp_en         = 1'b1;
        exp_pc         = 32'h100;
        @(negedge clk);
        cyc();
        cyc();

        // Reset values
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h100);
        chk("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
        chk("rst_dec_instr", dec_instr, 32'd0);
        chk("rst_dec_pc", dec_pc, 32'd0);

        // Reset release and first fetches
        rst_n     = 1'b1;
        dec_ready = 1'b1;
        settle();
        chk("rel_req_valid0", {31'b0, imem_req_valid}, 32'd0);
        cyc();
        chk("rel_req_valid1", {31'b0, imem_req_valid}, 32'd1);
        chk("rel_req_addr1", imem_req_addr, 32'h100);
        cyc();
        chk("rel_req_addr2", imem_req_addr, 32'h104);
        chk("rel_req_valid2", {31'b0, imem_req_valid}, 32'd1);
        chk("rel_dec_valid2", {31'b0, dec_valid}, 32'd0);
        cyc();
        chk("rel_dec_valid3", {31'b0, dec_valid}, 32'd1);
        chk("rel_dec_pc3", dec_pc, 32'h100);
        chk("rel_dec_instr3", dec_instr, 32'hFE01_AA93);
        chk("rel_opcode3", {25'b0, dec_opcode}, 32'h13);
        chk("rel_funct3_3", {29'b0, dec_funct3}, 32'd2);
        chk("rel_funct7_3", {25'b0, dec_funct7}, 32'h7F);
        chk("rel_req_addr3", imem_req_addr, 32'h108);
        chk("rel_req_valid3", {31'b0, imem_req_valid}, 32'd1);
        cyc_chk();

        // Sustained one instruction per cycle
        for (int i = 0; i < 6; i++) begin
            chk("stream_dec_valid", {31'b0, dec_valid}, 32'd1);
            chk("stream_req_valid", {31'b0, imem_req_valid}, 32'd1);
            chk("stream_req_addr", imem_req_addr, exp_pc + 32'd8);
            cyc_chk();
        end

        // Decode back-pressure for 10 cycles
        dec_ready = 1'b0;
        settle();
        for (int i = 0; i < 10; i++) begin
            chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
            cyc_chk();
        end
        chk("stall_dec_valid", {31'b0, dec_valid}, 32'd1);
        chk("stall_dec_pc", dec_pc, exp_pc);
        dec_ready = 1'b1;
        settle();
        chk("unstall_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("unstall_req_addr", imem_req_addr, exp_pc + 32'd8);
        pop_n(4);

        // Redirect with a full buffer
        dec_ready = 1'b0;
        settle();
        cyc_chk();
        cyc_chk();
        cyc_chk();
        chk("full_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("full_dec_valid", {31'b0, dec_valid}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        dec_ready      = 1'b1;
        settle();
        chk("redir1_dec_valid", {31'b0, dec_valid}, 32'd0);
        cyc();
        exp_pc = 32'h200;
        chk("redir1_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("redir1_req_addr", imem_req_addr, 32'h200);
        pop_n(3);

        // Redirect with two requests in flight; both stale responses dropped
        rsp_en = 1'b0;
        cyc_chk();
        cyc_chk();
        cyc_chk();
        cyc_chk();
        chk("infl_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("infl_dec_valid", {31'b0, dec_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h240;
        settle();
        cyc();
        rsp_en = 1'b1;
        exp_pc = 32'h240;
        chk("infl_hold1", {31'b0, imem_req_valid}, 32'd0);
        cyc();
        chk("infl_hold2", {31'b0, imem_req_valid}, 32'd0);
        cyc();
        chk("infl_req_valid3", {31'b0, imem_req_valid}, 32'd1);
        chk("infl_req_addr3", imem_req_addr, 32'h240);
        pop_n(3);

        // Redirect coinciding with a response and dec_ready
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        settle();
        chk("redir2_rsp_in", {31'b0, imem_rsp_valid}, 32'd1);
        chk("redir2_dec_valid", {31'b0, dec_valid}, 32'd0);
        cyc();
        exp_pc = 32'h300;
        chk("redir2_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("redir2_req_addr", imem_req_addr, 32'h300);
        pop_n(2);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        settle();
        cyc();
        exp_pc = 32'hFFFF_FFFC;
        chk("wrap_req_addr0", imem_req_addr, 32'hFFFF_FFFC);
        cyc_chk();
        chk("wrap_req_valid1", {31'b0, imem_req_valid}, 32'd1);
        chk("wrap_req_addr1", imem_req_addr, 32'h0000_0000);
        pop_n(3);

        // Misaligned redirect target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h202;
        settle();
        cyc();
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_fault_set", {31'b0, misalign_fault}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("mis_req_valid", {31'b0, imem_req_valid}, 32'd0);
            chk("mis_dec_valid", {31'b0, dec_valid}, 32'd0);
            cyc();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        settle();
        cyc();
        exp_pc = 32'h300;
        chk("mis_fault_clr", {31'b0, misalign_fault}, 32'd0);
        chk("mis_req_valid_exit", {31'b0, imem_req_valid}, 32'd1);
        chk("mis_req_addr_exit", imem_req_addr, 32'h300);
`else
        exp_pc = 32'h200;
        chk("mis_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("mis_req_addr", imem_req_addr, 32'h200);
`endif
        pop_n(2);

        // Reset mid-operation
        rst_n = 1'b0;
        settle();
        cyc();
        chk("mrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("mrst_req_addr", imem_req_addr, 32'h100);
        chk("mrst_dec_valid", {31'b0, dec_valid}, 32'd0);
        chk("mrst_dec_pc", dec_pc, 32'd0);
        chk("mrst_dec_instr", dec_instr, 32'd0);
        rst_n = 1'b1;
        settle();
        cyc();
        exp_pc = 32'h100;
        chk("mrst_req_valid1", {31'b0, imem_req_valid}, 32'd1);
        chk("mrst_req_addr1", imem_req_addr, 32'h100);
        pop_n(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
